// File: rtl/path_allocator.sv
// Round-robin path allocator for the 2x2 mesh: picks the primary or alternate route
// from the path-usage vector, grants one request at a time, tracks flits per source.
module path_allocator #(
    parameter int LEN_W = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [23:0]          path_usage,
    input  logic [3:0]           req_valid,
    input  logic [7:0]           req_dest,
    input  logic [4*LEN_W-1:0]   req_len,
    input  logic [3:0]           flit_done,
    output logic [3:0]           req_ready,
    output logic                 grant_valid,
    output logic [1:0]           grant_src,
    output logic [1:0]           grant_dest,
    output logic                 grant_path,
    output logic [3:0]           busy
);

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        HOLD
    } state_t;

    localparam logic [LEN_W-1:0] ONE = LEN_W'(1);

    state_t                  state_q, state_d;
    logic [1:0]              rr_ptr_q, rr_ptr_d;
    logic [3:0][LEN_W-1:0]   cnt_q, cnt_d;
    logic [3:0]              busy_q, busy_d;
    logic [3:0]              req_ready_q, req_ready_d;
    logic                    grant_valid_q, grant_valid_d;
    logic [1:0]              grant_src_q, grant_src_d;
    logic [1:0]              grant_dest_q, grant_dest_d;
    logic                    grant_path_q, grant_path_d;
    logic [LEN_W-1:0]        len_q, len_d;

    logic [3:0][1:0]         cls;
    logic [3:0][5:0]         field;
    logic [3:0]              pri_busy;
    logic [3:0]              alt_busy;
    logic [3:0]              eligible;
    logic [3:0]              alt_path;
    logic                    found;
    logic [1:0]              win;
    logic [1:0]              idx;

    // Class 0 (local) leaves both busy flags clear, so it is always eligible on path 0.
    always_comb begin
        cls      = '0;
        field    = '0;
        pri_busy = '0;
        alt_busy = '0;
        eligible = '0;
        alt_path = '0;
        for (int s = 0; s < 4; s++) begin
            cls[s]   = 2'(s) ^ req_dest[2*s +: 2];
            field[s] = path_usage[23-6*s -: 6];
            case (cls[s])
                2'd1: begin
                    pri_busy[s] = field[s][0];
                    alt_busy[s] = field[s][1];
                end
                2'd2: begin
                    pri_busy[s] = field[s][2];
                    alt_busy[s] = field[s][3];
                end
                2'd3: begin
                    pri_busy[s] = field[s][4];
                    alt_busy[s] = field[s][5];
                end
                default: begin
                    pri_busy[s] = 1'b0;
                    alt_busy[s] = 1'b0;
                end
            endcase
            eligible[s] = req_valid[s] && !busy_q[s] && (!pri_busy[s] || !alt_busy[s]);
            alt_path[s] = pri_busy[s];
        end
    end

    always_comb begin
        found = 1'b0;
        win   = rr_ptr_q;
        idx   = rr_ptr_q;
        for (int i = 0; i < 4; i++) begin
            idx = rr_ptr_q + 2'(i);
            if (!found && eligible[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        rr_ptr_d      = rr_ptr_q;
        req_ready_d   = '0;
        grant_valid_d = 1'b0;
        grant_src_d   = grant_src_q;
        grant_dest_d  = grant_dest_q;
        grant_path_d  = grant_path_q;
        len_d         = len_q;
        case (state_q)
            IDLE: begin
                if (found) begin
                    state_d       = GRANT;
                    grant_valid_d = 1'b1;
                    req_ready_d   = 4'b0001 << win;
                    grant_src_d   = win;
                    grant_dest_d  = req_dest[2*win +: 2];
                    grant_path_d  = alt_path[win];
                    len_d         = req_len[LEN_W*win +: LEN_W];
                    rr_ptr_d      = win + 2'd1;
                end
            end
            GRANT:   state_d = HOLD;
            HOLD:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // The granted source cannot already be busy, so the load never collides with a decrement.
    always_comb begin
        cnt_d  = cnt_q;
        busy_d = busy_q;
        for (int s = 0; s < 4; s++) begin
            if (state_q == GRANT && grant_src_q == 2'(s)) begin
                cnt_d[s]  = (len_q == '0) ? ONE : len_q;
                busy_d[s] = 1'b1;
            end else if (flit_done[s] && busy_q[s]) begin
                cnt_d[s] = cnt_q[s] - ONE;
                if (cnt_q[s] == ONE) begin
                    busy_d[s] = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            rr_ptr_q      <= '0;
            cnt_q         <= '0;
            busy_q        <= '0;
            req_ready_q   <= '0;
            grant_valid_q <= 1'b0;
            grant_src_q   <= '0;
            grant_dest_q  <= '0;
            grant_path_q  <= 1'b0;
            len_q         <= '0;
        end else begin
            state_q       <= state_d;
            rr_ptr_q      <= rr_ptr_d;
            cnt_q         <= cnt_d;
            busy_q        <= busy_d;
            req_ready_q   <= req_ready_d;
            grant_valid_q <= grant_valid_d;
            grant_src_q   <= grant_src_d;
            grant_dest_q  <= grant_dest_d;
            grant_path_q  <= grant_path_d;
            len_q         <= len_d;
        end
    end

    assign req_ready   = req_ready_q;
    assign grant_valid = grant_valid_q;
    assign grant_src   = grant_src_q;
    assign grant_dest  = grant_dest_q;
    assign grant_path  = grant_path_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_path_allocator.sv
// Self-checking bench for path_allocator: directed scenarios with literal expectations
// plus randomized traffic compared every cycle against a behavioural model.
module tb_path_allocator;

    localparam int LEN_W = 4;

    logic                 clk = 1'b0;
    logic                 rst = 1'b0;
    logic [23:0]          path_usage = '0;
    logic [3:0]           req_valid = '0;
    logic [7:0]           req_dest = '0;
    logic [4*LEN_W-1:0]   req_len = '0;
    logic [3:0]           flit_done = '0;
    logic [3:0]           req_ready;
    logic                 grant_valid;
    logic [1:0]           grant_src;
    logic [1:0]           grant_dest;
    logic                 grant_path;
    logic [3:0]           busy;

    int testsRun = 0;
    int testsFailed = 0;

    path_allocator #(.LEN_W(LEN_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .path_usage  (path_usage),
        .req_valid   (req_valid),
        .req_dest    (req_dest),
        .req_len     (req_len),
        .flit_done   (flit_done),
        .req_ready   (req_ready),
        .grant_valid (grant_valid),
        .grant_src   (grant_src),
        .grant_dest  (grant_dest),
        .grant_path  (grant_path),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    // Behavioural model: phase 0/1/2 = evaluate/grant/settle; a source is busy while flits remain.
    int       mPhase = 0;
    int       mRr = 0;
    int       mCnt [4] = '{0, 0, 0, 0};
    bit       mGv = 1'b0;
    logic [3:0] mReady = '0;
    int       mSrc = 0;
    int       mDest = 0;
    int       mPath = 0;
    int       mLen = 0;

    // Returns -1 when both routes are taken, else the route index.
    function automatic int pathChoice(int s, int d, logic [23:0] pu);
        int cls;
        int b;
        cls = s ^ d;
        if (cls == 0) return 0;
        b = 18 - 6*s + 2*(cls - 1);
        if (!pu[b]) return 0;
        if (!pu[b+1]) return 1;
        return -1;
    endfunction

    always @(posedge clk or negedge rst) begin
        int loadSrc;
        int loadLen;
        int nextPhase;
        int s;
        int p;
        bit got;
        if (!rst) begin
            mPhase = 0;
            mRr    = 0;
            for (int i = 0; i < 4; i++) mCnt[i] = 0;
            mGv    = 1'b0;
            mReady = '0;
            mSrc   = 0;
            mDest  = 0;
            mPath  = 0;
            mLen   = 0;
        end else begin
            loadSrc = -1;
            loadLen = 0;
            if (mPhase == 1) begin
                loadSrc = mSrc;
                loadLen = (mLen == 0) ? 1 : mLen;
            end
            mGv    = 1'b0;
            mReady = '0;
            nextPhase = (mPhase == 1) ? 2 : 0;
            if (mPhase == 0) begin
                got = 1'b0;
                for (int i = 0; i < 4; i++) begin
                    s = (mRr + i) % 4;
                    if (!got && req_valid[s] && mCnt[s] == 0) begin
                        p = pathChoice(s, int'(req_dest[2*s +: 2]), path_usage);
                        if (p >= 0) begin
                            got    = 1'b1;
                            mGv    = 1'b1;
                            mReady = 4'(1 << s);
                            mSrc   = s;
                            mDest  = int'(req_dest[2*s +: 2]);
                            mPath  = p;
                            mLen   = int'(req_len[LEN_W*s +: LEN_W]);
                            mRr    = (s + 1) % 4;
                        end
                    end
                end
                nextPhase = got ? 1 : 0;
            end
            mPhase = nextPhase;
            for (int i = 0; i < 4; i++) begin
                if (flit_done[i] && mCnt[i] > 0) mCnt[i] = mCnt[i] - 1;
                if (i == loadSrc) mCnt[i] = loadLen;
            end
        end
    end

    task automatic checkOutput();
        logic [3:0] expBusy;
        for (int i = 0; i < 4; i++) expBusy[i] = (mCnt[i] != 0);
        testsRun++;
        if (req_ready !== mReady || grant_valid !== mGv || grant_src !== 2'(mSrc) ||
            grant_dest !== 2'(mDest) || grant_path !== 1'(mPath)) begin
            testsFailed++;
            $display("[TB] FAIL grant outputs t=%0t: got ready=%b gv=%b src=%0d dest=%0d path=%0d, expected ready=%b gv=%b src=%0d dest=%0d path=%0d",
                     $time, req_ready, grant_valid, grant_src, grant_dest, grant_path,
                     mReady, mGv, mSrc, mDest, mPath);
        end
        testsRun++;
        if (busy !== expBusy) begin
            testsFailed++;
            $display("[TB] FAIL busy t=%0t: got %b, expected %b", $time, busy, expBusy);
        end
    endtask

    always @(negedge clk) checkOutput();

    task automatic checkValue(input string name, input int actual, input int expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Advance one cycle; requesters withdraw once accepted, flit pulses last one cycle.
    task automatic stepCycle();
        @(negedge clk);
        req_valid = req_valid & ~req_ready;
        flit_done = '0;
    endtask

    task automatic setReq(input int s, input int d, input int len);
        req_valid[s]             = 1'b1;
        req_dest[2*s +: 2]       = 2'(d);
        req_len[LEN_W*s +: LEN_W] = LEN_W'(len);
    endtask

    task automatic waitGrant(input int maxCycles, output int src);
        src = -1;
        for (int c = 0; c < maxCycles; c++) begin
            stepCycle();
            if (grant_valid === 1'b1) begin
                src = int'(grant_src);
                return;
            end
        end
        testsRun++;
        testsFailed++;
        $display("[TB] FAIL grant timeout: got no grant within %0d cycles, expected a grant", maxCycles);
    endtask

    task automatic pulseFlits(input int s, input int n);
        stepCycle();
        for (int i = 0; i < n; i++) begin
            flit_done[s] = 1'b1;
            stepCycle();
        end
        checkValue("busy cleared after last flit", int'(busy[s]), 0);
    endtask

    task automatic doReset();
        @(negedge clk);
        rst        = 1'b0;
        req_valid  = '0;
        flit_done  = '0;
        path_usage = '0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic applyStimulus(input int cycles);
        for (int c = 0; c < cycles; c++) begin
            stepCycle();
            if ($urandom_range(0, 3) == 0) path_usage = 24'($urandom & $urandom);
            for (int s = 0; s < 4; s++) begin
                if (!req_valid[s] && $urandom_range(0, 99) < 30)
                    setReq(s, int'($urandom_range(0, 3)), int'($urandom_range(0, 15)));
                else if (req_valid[s] && $urandom_range(0, 99) < 3)
                    req_valid[s] = 1'b0;
                flit_done[s] = ($urandom_range(0, 99) < 40);
            end
        end
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int g;
        int seen;
        int nGrants;
        int order [$];
        int when [$];

        // Reset state, then a single primary-route grant of three flits
        repeat (3) @(negedge clk);
        checkValue("reset grant_valid", int'(grant_valid), 0);
        checkValue("reset busy", int'(busy), 0);
        checkValue("reset req_ready", int'(req_ready), 0);
        checkValue("reset grant_src", int'(grant_src), 0);
        rst = 1'b1;
        stepCycle();
        setReq(0, 1, 3);
        stepCycle();
        checkValue("first grant_valid", int'(grant_valid), 1);
        checkValue("first req_ready", int'(req_ready), 1);
        checkValue("first grant_src", int'(grant_src), 0);
        checkValue("first grant_dest", int'(grant_dest), 1);
        checkValue("first grant_path", int'(grant_path), 0);
        stepCycle();
        checkValue("busy after grant", int'(busy), 1);
        checkValue("grant pulse one cycle", int'(grant_valid), 0);
        flit_done[0] = 1'b1;
        stepCycle();
        flit_done[0] = 1'b1;
        stepCycle();
        checkValue("busy before third flit", int'(busy), 1);
        flit_done[0] = 1'b1;
        stepCycle();
        checkValue("busy after third flit", int'(busy), 0);

        // Primary busy picks the alternate; both busy blocks until the alternate frees up
        stepCycle();
        path_usage = 24'h040000;
        setReq(0, 1, 1);
        waitGrant(10, g);
        checkValue("alt route src", g, 0);
        checkValue("alt route path", int'(grant_path), 1);
        pulseFlits(0, 1);
        path_usage = 24'h0C0000;
        setReq(0, 1, 1);
        seen = 0;
        repeat (6) begin
            stepCycle();
            if (grant_valid === 1'b1) seen++;
        end
        checkValue("blocked request grants", seen, 0);
        path_usage = 24'h040000;
        waitGrant(10, g);
        checkValue("unblocked path", int'(grant_path), 1);
        pulseFlits(0, 1);

        // All four request together after reset: order 0..3, three cycles apart
        doReset();
        for (int s = 0; s < 4; s++) setReq(s, (s + 1) % 4, 1);
        for (int c = 0; c < 30; c++) begin
            stepCycle();
            if (grant_valid === 1'b1) begin
                order.push_back(int'(grant_src));
                when.push_back(c);
            end
        end
        checkValue("round-robin grant count", order.size(), 4);
        for (int i = 0; i < order.size(); i++) checkValue("round-robin order", order[i], i);
        for (int i = 1; i < when.size(); i++) checkValue("grant spacing", when[i] - when[i-1], 3);
        stepCycle();
        flit_done = 4'hF;
        stepCycle();
        checkValue("all transfers done", int'(busy), 0);

        // Local request ignores a fully busy mesh
        path_usage = 24'hFFFFFF;
        setReq(2, 2, 2);
        waitGrant(10, g);
        checkValue("local src", g, 2);
        checkValue("local path", int'(grant_path), 0);
        checkValue("local dest", int'(grant_dest), 2);
        pulseFlits(2, 2);

        // Zero length counts as one flit; stray flits on an idle source are ignored
        path_usage = '0;
        setReq(3, 0, 0);
        waitGrant(10, g);
        checkValue("len0 src", g, 3);
        pulseFlits(3, 1);
        flit_done[3] = 1'b1;
        stepCycle();
        flit_done[3] = 1'b1;
        stepCycle();
        checkValue("stray flits keep idle", int'(busy[3]), 0);
        setReq(3, 0, 2);
        waitGrant(10, g);
        stepCycle();
        flit_done[3] = 1'b1;
        stepCycle();
        checkValue("len2 busy after one flit", int'(busy[3]), 1);
        flit_done[3] = 1'b1;
        stepCycle();
        checkValue("len2 done after two flits", int'(busy[3]), 0);

        // Reset in HOLD with three transfers in flight
        doReset();
        setReq(0, 1, 5);
        setReq(1, 0, 5);
        setReq(3, 1, 5);
        nGrants = 0;
        for (int c = 0; c < 20 && nGrants < 3; c++) begin
            stepCycle();
            if (grant_valid === 1'b1) nGrants++;
        end
        checkValue("grants before abort", nGrants, 3);
        stepCycle();
        checkValue("busy before abort", int'(busy), 11);
        #2;
        rst = 1'b0;
        #1;
        checkValue("abort grant_valid", int'(grant_valid), 0);
        checkValue("abort busy", int'(busy), 0);
        checkValue("abort req_ready", int'(req_ready), 0);
        checkValue("abort grant_src", int'(grant_src), 0);
        checkValue("abort grant_dest", int'(grant_dest), 0);
        checkValue("abort grant_path", int'(grant_path), 0);
        @(negedge clk);
        rst = 1'b1;
        stepCycle();
        setReq(1, 0, 1);
        setReq(0, 1, 1);
        waitGrant(10, g);
        checkValue("first grant after abort", g, 0);

        // Random traffic, checked every cycle by the model
        applyStimulus(2000);
        req_valid = '0;
        repeat (10) stepCycle();

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
